bram_arbiter: RTL and testbench

- Shares the single-port frame BRAM between three requesters: camera writer (0), blur engine (1) and edge-detection engine (2).
- Uses round-robin arbitration with optional burst locking.
- Drives the BRAM port from registers and returns each read's data to the requester that issued it, tagged by a latency pipeline.
- Sits between the processing engines and the frame BRAM. The main FSM uses `halt` to freeze access during state changes.

---
 rtl/bram_arbiter.sv | 148 ++++++++++++++
 tb/tb_bram_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing the single-port frame BRAM between three requesters,
// with optional burst locking and tagged return of read data.
module bram_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt,
  input  logic [2:0]          req,
  input  logic [2:0]          lock,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic                bram_we,
  output logic [DATA_W-1:0]   bram_din,
  input  logic [DATA_W-1:0]   bram_dout,
  output logic                busy
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEPTH = RD_LATENCY + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_n;
  logic [1:0]        ptr, ptr_n;
  logic [1:0]        owner, owner_n;
  logic [CNT_W-1:0]  cnt, cnt_n;

  logic              gnt_any;
  logic [1:0]        gnt_idx;
  logic [1:0]        c1, c2;
  logic              arb_hit;
  logic [1:0]        arb_idx;

  logic [ADDR_W-1:0] addr_a  [3];
  logic [DATA_W-1:0] wdata_a [3];

  logic [DEPTH-1:0]  pipe_v;
  logic [1:0]        pipe_id [DEPTH];

  // Unpack the per-requester address and write-data lanes
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
      wdata_a[i] = wdata[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin pick: search starts just after the last grantee, which comes last
  always_comb begin
    c1      = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    c2      = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    arb_hit = 1'b1;
    arb_idx = ptr;
    if (req[c1])       arb_idx = c1;
    else if (req[c2])  arb_idx = c2;
    else if (req[ptr]) arb_idx = ptr;
    else               arb_hit = 1'b0;
  end

  // Next-state and grant decode
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = cnt;
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    if (!reset && !halt) begin
      if (state == BURST && req[owner] && lock[owner] && cnt < CNT_W'(MAX_BURST)) begin
        gnt_any = 1'b1;
        gnt_idx = owner;
        cnt_n   = cnt + CNT_W'(1);
      end else begin
        state_n = IDLE;
        if (arb_hit) begin
          gnt_any = 1'b1;
          gnt_idx = arb_idx;
          ptr_n   = arb_idx;
          if (lock[arb_idx]) begin
            state_n = BURST;
            owner_n = arb_idx;
            cnt_n   = CNT_W'(1);
          end
        end
      end
    end
  end

  assign gnt = gnt_any ? (3'b001 << gnt_idx) : 3'b000;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 2'd2;
      owner <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      cnt   <= cnt_n;
    end
  end

  // BRAM port registers; address and data hold when idle, write enable drops
  always_ff @(posedge clk) begin
    if (reset) begin
      bram_addr <= '0;
      bram_we   <= 1'b0;
      bram_din  <= '0;
    end else if (gnt_any) begin
      bram_addr <= addr_a[gnt_idx];
      bram_we   <= we[gnt_idx];
      bram_din  <= wdata_a[gnt_idx];
    end else begin
      bram_we   <= 1'b0;
    end
  end

  // Tag pipeline: final stage lines up with bram_dout of the matching read
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v <= '0;
      for (int k = 0; k < int'(DEPTH); k++) pipe_id[k] <= 2'd0;
    end else begin
      pipe_v[0]  <= gnt_any && !we[gnt_idx];
      pipe_id[0] <= gnt_idx;
      for (int k = 1; k < int'(DEPTH); k++) begin
        pipe_v[k]  <= pipe_v[k-1];
        pipe_id[k] <= pipe_id[k-1];
      end
    end
  end

  assign rd_valid = pipe_v[DEPTH-1] ? (3'b001 << pipe_id[DEPTH-1]) : 3'b000;
  assign rd_data  = pipe_v[DEPTH-1] ? bram_dout : '0;
  assign busy     = gnt_any | (|pipe_v);

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: directed stimulus queues expected grants,
// BRAM port values and read returns; a negedge monitor compares them.
module tb_bram_arbiter;

  localparam int AW  = 17;
  localparam int DW  = 12;
  localparam int LAT = 2;
  localparam int MB  = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            halt = 1'b0;
  logic [2:0]      req = 3'b000;
  logic [2:0]      lock = 3'b000;
  logic [2:0]      we = 3'b000;
  logic [AW-1:0]   ta [3];
  logic [DW-1:0]   td [3];
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt, rd_valid;
  logic [DW-1:0]   rd_data, bram_din, bram_dout;
  logic [AW-1:0]   bram_addr;
  logic            bram_we, busy;

  assign addr  = {ta[2], ta[1], ta[0]};
  assign wdata = {td[2], td[1], td[0]};

  bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .halt(halt), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din),
    .bram_dout(bram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: returns address+1, two cycles after the address is presented
  logic [AW-1:0] h0, h1;
  always @(posedge clk) begin
    h0 <= bram_addr;
    h1 <= h0;
  end
  assign bram_dout = DW'(h1 + AW'(1));

  typedef struct {
    int          cyc;
    logic [2:0]  v;
    logic [AW-1:0] a;
    logic        w;
    logic [DW-1:0] d;
  } exp_t;

  exp_t gq[$];
  exp_t pq[$];
  exp_t rq[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue one expected access by requester i granted in the current cycle
  task automatic acc(input int i, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input bit rd_exp);
    exp_t e;
    e.cyc = cyc;
    e.v   = 3'(1 << i);
    e.a   = a;
    e.w   = w;
    e.d   = d;
    gq.push_back(e);
    e.cyc = cyc + 1;
    pq.push_back(e);
    if (!w && rd_exp) begin
      e.cyc = cyc + 1 + LAT;
      e.d   = DW'(a + AW'(1));
      rq.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"},       32'(gnt),       32'd0);
    check({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
    check({tag, "_rd_data"},   32'(rd_data),   32'd0);
    check({tag, "_bram_addr"}, 32'(bram_addr), 32'd0);
    check({tag, "_bram_we"},   32'(bram_we),   32'd0);
    check({tag, "_bram_din"},  32'(bram_din),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    exp_t e;
    if (gnt !== 3'b000) begin
      if (gq.size() == 0) check("gnt_unexpected", 32'(gnt), 32'd0);
      else begin
        e = gq.pop_front();
        check("gnt_value", 32'(gnt), 32'(e.v));
        check("gnt_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (gq.size() != 0 && gq[0].cyc <= cyc) begin
      e = gq.pop_front();
      check("gnt_missing", 32'(gnt), 32'(e.v));
    end

    if (pq.size() != 0 && pq[0].cyc == cyc) begin
      e = pq.pop_front();
      check("bram_addr", 32'(bram_addr), 32'(e.a));
      check("bram_we",   32'(bram_we),   32'(e.w));
      if (e.w) check("bram_din", 32'(bram_din), 32'(e.d));
    end else if (bram_we !== 1'b0) begin
      check("bram_we_unexpected", 32'(bram_we), 32'd0);
    end

    if (rd_valid !== 3'b000) begin
      if (rq.size() == 0) check("rd_unexpected", 32'(rd_valid), 32'd0);
      else begin
        e = rq.pop_front();
        check("rd_valid", 32'(rd_valid), 32'(e.v));
        check("rd_data",  32'(rd_data),  32'(e.d));
        check("rd_cycle", 32'(cyc),      32'(e.cyc));
      end
    end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
      e = rq.pop_front();
      check("rd_missing", 32'(rd_valid), 32'(e.v));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    foreach (ta[i]) ta[i] = '0;
    foreach (td[i]) td[i] = '0;
    step();
    step();
    check_reset_vals("reset");
    reset = 1'b0;
    step();

    // Three-way round robin with no locking
    ta[0] = 17'h00100; ta[1] = 17'h00200; ta[2] = 17'h00300;
    req = 3'b111;
    acc(0, 1'b0, 17'h00100, 12'h000, 1'b1); step();
    acc(1, 1'b0, 17'h00200, 12'h000, 1'b1); step();
    acc(2, 1'b0, 17'h00300, 12'h000, 1'b1); step();
    acc(0, 1'b0, 17'h00100, 12'h000, 1'b1); step();
    req = 3'b000;
    repeat (6) step();

    // Single read from requester 1, data = addr+1 three cycles after the grant
    ta[1] = 17'h00010;
    req = 3'b010;
    acc(1, 1'b0, 17'h00010, 12'h000, 1'b1); step();
    req = 3'b000;
    repeat (5) step();

    // Move the pointer to 2, then a locked burst from 0 competing with 2
    ta[2] = 17'h00500; td[2] = 12'h222; we = 3'b100;
    req = 3'b100;
    acc(2, 1'b1, 17'h00500, 12'h222, 1'b0); step();
    ta[0] = 17'h00400; td[0] = 12'h111; we = 3'b101;
    req = 3'b101; lock = 3'b001;
    for (int k = 0; k < 40; k++) begin
      if (k % (MB + 1) == MB) acc(2, 1'b1, 17'h00500, 12'h222, 1'b0);
      else                    acc(0, 1'b1, 17'h00400, 12'h111, 1'b0);
      step();
    end
    req = 3'b000; lock = 3'b000; we = 3'b000;
    repeat (4) step();

    // Three back-to-back reads, then halt with everyone requesting
    ta[1] = 17'h00020; req = 3'b010;
    acc(1, 1'b0, 17'h00020, 12'h000, 1'b1); step();
    ta[2] = 17'h00030; req = 3'b100;
    acc(2, 1'b0, 17'h00030, 12'h000, 1'b1); step();
    ta[0] = 17'h00040; req = 3'b001;
    acc(0, 1'b0, 17'h00040, 12'h000, 1'b1); step();
    halt = 1'b1; req = 3'b111;
    step();
    step();
    check("halt_busy_last_rd", 32'(busy), 32'd1);
    step();
    check("halt_busy_drained", 32'(busy), 32'd0);
    step();
    halt = 1'b0; req = 3'b000;
    repeat (3) step();

    // Write at the top address from requester 0
    ta[0] = 17'h1FFFF; td[0] = 12'hABC; we = 3'b001; req = 3'b001;
    acc(0, 1'b1, 17'h1FFFF, 12'hABC, 1'b0); step();
    req = 3'b000; we = 3'b000;
    step();
    check("write_we_drop", 32'(bram_we), 32'd0);
    repeat (4) step();

    // Reset one cycle after a read grant discards the read
    ta[1] = 17'h00050; req = 3'b010;
    acc(1, 1'b0, 17'h00050, 12'h000, 1'b0); step();
    req = 3'b000; reset = 1'b1;
    step();
    check_reset_vals("midreset");
    reset = 1'b0;
    repeat (5) step();
    ta[0] = 17'h00060; req = 3'b111;
    acc(0, 1'b0, 17'h00060, 12'h000, 1'b1); step();
    req = 3'b000;
    repeat (8) step();

    check("gnt_queue_drained", 32'(gq.size()), 32'd0);
    check("port_queue_drained", 32'(pq.size()), 32'd0);
    check("rd_queue_drained", 32'(rq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
